fifo_wr_arb: RTL
================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter WIDTH, default 32, data width of each beat and of the shared FIFO.
REQ-002 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-003 Parameter BURST, default 4, maximum beats per grant (1..16).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester beat valid.
REQ-007 req_data  input  NREQ*WIDTH  per-requester beat data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_last  input  NREQ  marks final beat of a requester's packet.
REQ-009 req_ready  output  NREQ  per-requester beat accept.
REQ-010 fifo_wr_en  output  1  write strobe to shared FIFO.
REQ-011 fifo_din  output  WIDTH  write data to shared FIFO.
REQ-012 fifo_prog_full  input  1  FIFO programmable-full backpressure.
REQ-013 grant_id  output  $clog2(NREQ)  index of current or last granted requester.
REQ-014 busy  output  1  high while in state XFER.
REQ-015 stat_beats  output  NREQ*16  per-requester accepted-beat counters (see Configuration).

Function
REQ-016 FSM states IDLE and XFER only.
REQ-017 IDLE: if any req_valid high and fifo_prog_full low, the block SHALL select the first valid requester strictly after the previous grant_id (round-robin, wrapping NREQ-1 -> 0), load grant_id, and enter XFER next cycle; otherwise it SHALL remain in IDLE.
REQ-018 XFER: req_ready[grant_id] = !fifo_prog_full; all other req_ready bits 0; in IDLE all req_ready bits 0.
REQ-019 A beat is accepted when req_valid[g] & req_ready[g] in XFER; fifo_wr_en SHALL pulse exactly one cycle later, with fifo_din equal to the accepted req_data (1-cycle registered latency).
REQ-020 fifo_wr_en SHALL be 0 in any cycle not following an accepted beat; fifo_din holds its last value when fifo_wr_en is 0.
REQ-021 A beat counter SHALL increment per accepted beat; XFER exits to IDLE on the accepted beat with req_last high or with count == BURST-1; the counter clears on exit.
REQ-022 req_valid low, or fifo_prog_full high, during XFER SHALL stall without leaving XFER or losing the beat count.
REQ-023 Minimum one IDLE cycle between consecutive grants; a single active requester thus sustains BURST beats per BURST+1 cycles.
REQ-024 fifo_prog_full rising in the same cycle as an accept SHALL still allow that beat; the next beat is blocked.

Reset
REQ-025 On rst: state IDLE, req_ready 0, fifo_wr_en 0, fifo_din 0, busy 0, beat counter 0, stat_beats 0, grant_id NREQ-1 (requester 0 wins first arbitration).
REQ-026 rst mid-XFER SHALL abort the burst; a beat accepted in the cycle before rst SHALL NOT produce fifo_wr_en after reset.

Configuration
REQ-027 Macro FIFO_WR_ARB_STAT_EN: when defined, stat_beats[i*16 +: 16] SHALL count accepted beats of requester i, saturating at 16'hFFFF; when undefined, stat_beats SHALL be constant 0 and no counter registers exist.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, XFER) and the stat counter width constant (16).
REQ-029 Sub-module rr_pick (combinational round-robin picker: request vector and previous index in, next index and found flag out) SHALL be instantiated once.

Verification (WIDTH=32, NREQ=4, BURST=4)
REQ-030 Reset release, req_valid=4'b0000 -> state IDLE, fifo_wr_en 0, grant_id=3, stat_beats 0 indefinitely.
REQ-031 Requesters 0 and 2 valid continuously, no req_last -> grants alternate 0,2,0,2; each grant yields exactly 4 fifo_wr_en pulses carrying that requester's data in order.
REQ-032 Requester 1 sends 2 beats with req_last on beat 2 -> exactly 2 writes, return to IDLE, grant_id stays 1.
REQ-033 fifo_prog_full held high for 5 cycles after beat 2 of a burst -> req_ready 0 for those 5 cycles, no writes, remaining 2 beats written after release.
REQ-034 rst asserted in the cycle after beat 3 is accepted -> no fifo_wr_en after reset; next grant goes to requester 0.
REQ-035 FIFO_WR_ARB_STAT_EN defined, requester 3 sends 10 beats -> stat_beats[63:48]=10, other counters 0; macro undefined -> stat_beats=0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared FSM state type and stat counter width for fifo_wr_arb
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request strictly after prev_i
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   prev_i,
  output logic [IW-1:0]   idx_o,
  output logic            found_o
);

  int j;

  // Scan from farthest to nearest so the nearest candidate after prev_i wins.
  always_comb begin
    idx_o   = prev_i;
    found_o = 1'b0;
    j       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(prev_i) + k) % NREQ;
      if (req_i[j]) begin
        idx_o   = j[IW-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter of NREQ writers onto one FIFO write port
// Optional per-requester beat statistics: FIFO_WR_ARB_STAT_EN.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_din,
  input  logic                     fifo_prog_full,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [NREQ*STAT_W-1:0]   stat_beats
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  state_e           state_q;
  logic [IW-1:0]    grant_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_en_q;
  logic [WIDTH-1:0] din_q;

  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic             accept;
  logic             last_beat;
  logic [WIDTH-1:0] gnt_data;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i   (req_valid),
    .prev_i  (grant_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign gnt_data  = req_data[grant_q*WIDTH +: WIDTH];
  assign accept    = (state_q == XFER) && req_valid[grant_q] && !fifo_prog_full;
  assign last_beat = req_last[grant_q] || (cnt_q == CW'(BURST - 1));

  always_comb begin
    req_ready = '0;
    if (state_q == XFER) req_ready[grant_q] = !fifo_prog_full;
  end

  // Reset clears wr_en_q, so a beat accepted just before reset never reaches the FIFO afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= IW'(NREQ - 1);
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      din_q   <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) din_q <= gnt_data;
      case (state_q)
        IDLE: begin
          if (pick_found && !fifo_prog_full) begin
            grant_q <= pick_idx;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            if (last_beat) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q == XFER);

`ifdef FIFO_WR_ARB_STAT_EN
  logic [STAT_W-1:0] stat_q [NREQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst) begin
        stat_q[i] <= '0;
      end else if (accept && (grant_q == IW'(i)) && (stat_q[i] != {STAT_W{1'b1}})) begin
        stat_q[i] <= stat_q[i] + STAT_W'(1);
      end
    end
  end

  always_comb begin
    stat_beats = '0;
    for (int i = 0; i < NREQ; i++) stat_beats[i*STAT_W +: STAT_W] = stat_q[i];
  end
`else
  assign stat_beats = '0;
`endif

endmodule
